// File: rtl/bootram_ctrl_pkg.sv
// Shared constants for the boot RAM controller: FSM encoding, lane count, capacity helpers.
// Purely declarative, no latency or backpressure of its own.
package bootram_ctrl_pkg;

  localparam int LANES          = 4;
  localparam int ADDR_W_DEFAULT = 11;
  localparam int RAM_BYTES      = LANES * (2 ** ADDR_W_DEFAULT);

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_RD_WAIT = 3'd1;
  localparam state_t ST_RD_ACK  = 3'd2;
  localparam state_t ST_WR_ACK  = 3'd3;
  localparam state_t ST_LOAD    = 3'd4;
  localparam state_t ST_LD_FIN  = 3'd5;

  function automatic int ram_bytes(input int addr_w);
    return LANES * (2 ** addr_w);
  endfunction

  function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/bootram_ctrl.sv
// Boot RAM master: arbitrates PicoRV32 bus and byte loader onto four BSRAM byte lanes.
// Latency: read 2 clk valid->ready, write 1 clk, loader 1 byte/clk; CPU stalls during a load.
// Optional write lock after a completed load: define BOOTRAM_CTRL_WPROT_EN.
module bootram_ctrl
  import bootram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int LANES  = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 mem_valid,
  input  logic                 mem_sel,
  input  logic [ADDR_W+1:0]    mem_addr,
  input  logic [LANES-1:0]     mem_wstrb,
  input  logic [8*LANES-1:0]   mem_wdata,
  output logic [8*LANES-1:0]   mem_rdata,
  output logic                 mem_ready,
  input  logic                 ld_valid,
  input  logic [7:0]           ld_data,
  input  logic                 ld_last,
  output logic                 ld_ready,
  output logic                 ld_done,
  output logic                 ld_ovf,
  output logic [LANES-1:0]     ram_ce,
  output logic [LANES-1:0]     ram_wre,
  output logic [ADDR_W-1:0]    ram_ad,
  output logic [8*LANES-1:0]   ram_din,
  input  logic [8*LANES-1:0]   ram_dout
`ifdef BOOTRAM_CTRL_WPROT_EN
  ,
  output logic                 wprot_err
`endif
);

  localparam int CNT_W = ADDR_W + 3;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ram_bytes(ADDR_W));

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 ovf_q;
  logic [8*LANES-1:0]   rdata_q;
  logic                 cpu_req;
  logic                 wr_start;
  logic                 ld_accept;
  logic                 cnt_full;
  logic                 wr_allow;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^mem_addr[1:0];

  assign cpu_req   = mem_valid & mem_sel;
  assign wr_start  = (state_q == ST_IDLE) & ~ld_valid & cpu_req & (mem_wstrb != '0);
  assign ld_accept = (state_q == ST_LOAD) & ld_valid;
  assign cnt_full  = (cnt_q == CNT_MAX);

  assign mem_ready = (state_q == ST_RD_ACK) | (state_q == ST_WR_ACK);
  assign mem_rdata = rdata_q;
  assign ld_ready  = (state_q == ST_LOAD);
  assign ld_done   = (state_q == ST_LD_FIN);
  assign ld_ovf    = ovf_q;

`ifdef BOOTRAM_CTRL_WPROT_EN
  logic lock_q;
  logic blocked_q;

  // Lock arms on load completion and is released only by the next load session.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q    <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && ld_valid) begin
        lock_q <= 1'b0;
      end else if (state_q == ST_LD_FIN) begin
        lock_q <= 1'b1;
      end
      blocked_q <= wr_start & lock_q;
    end
  end

  assign wr_allow  = ~lock_q;
  assign wprot_err = blocked_q;
`else
  assign wr_allow  = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    ram_ce  = '0;
    ram_wre = '0;
    ram_ad  = '0;
    ram_din = '0;
    case (state_q)
      ST_IDLE: begin
        if (ld_valid) begin
          state_d = ST_LOAD;
        end else if (cpu_req) begin
          ram_ad = mem_addr[ADDR_W+1:2];
          if (mem_wstrb == '0) begin
            ram_ce  = '1;
            state_d = ST_RD_WAIT;
          end else begin
            if (wr_allow) begin
              ram_ce  = mem_wstrb;
              ram_wre = mem_wstrb;
            end
            ram_din = mem_wdata;
            state_d = ST_WR_ACK;
          end
        end
      end
      ST_RD_WAIT: state_d = ST_RD_ACK;
      ST_RD_ACK:  state_d = ST_IDLE;
      ST_WR_ACK:  state_d = ST_IDLE;
      ST_LOAD: begin
        if (ld_valid) begin
          // Bytes past capacity are still acknowledged but never reach the lanes.
          if (!cnt_full) begin
            ram_ce  = lane_onehot(cnt_q[1:0]);
            ram_wre = lane_onehot(cnt_q[1:0]);
            ram_ad  = cnt_q[ADDR_W+1:2];
          end
          ram_din = {LANES{ld_data}};
          if (ld_last) begin
            state_d = ST_LD_FIN;
          end
        end
      end
      ST_LD_FIN:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && ld_valid) begin
        cnt_q <= '0;
      end else if (ld_accept && !cnt_full) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (ld_accept && cnt_full) begin
        ovf_q <= 1'b1;
      end
      // Lane data is valid the clock after the CE edge.
      if (state_q == ST_RD_WAIT) begin
        rdata_q <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_bootram_ctrl.sv
// Randomized scoreboard bench for bootram_ctrl with a byte-array reference memory and a BSRAM lane model.
// Build with BOOTRAM_CTRL_WPROT_EN defined to exercise the write lock.
module tb_bootram_ctrl;

  localparam int AW    = 11;
  localparam int WORDS = 2 ** AW;
  localparam int NB    = 4 * WORDS;
`ifdef BOOTRAM_CTRL_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        mem_valid, mem_sel;
  logic [12:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        ld_valid, ld_last, ld_ready, ld_done, ld_ovf;
  logic [7:0]  ld_data;
  logic [3:0]  ram_ce, ram_wre;
  logic [10:0] ram_ad;
  logic [31:0] ram_din, ram_dout;
`ifdef BOOTRAM_CTRL_WPROT_EN
  logic        wprot_err;
`endif

  bootram_ctrl #(.ADDR_W(AW), .LANES(4)) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .ld_done(ld_done), .ld_ovf(ld_ovf),
    .ram_ce(ram_ce), .ram_wre(ram_wre), .ram_ad(ram_ad), .ram_din(ram_din), .ram_dout(ram_dout)
`ifdef BOOTRAM_CTRL_WPROT_EN
    , .wprot_err(wprot_err)
`endif
  );

  typedef struct packed {
    logic        is_rd;
    logic        prot;
    logic [31:0] data;
  } exp_t;

  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         done_cyc, ready_cyc;
  exp_t       sb_q[$];
  logic [7:0] ref_mem [NB];
  logic [7:0] img[$];
  logic [7:0] ram_mem [4][WORDS];
  logic       ref_lock;
  logic       exp_ovf;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Four 2Kx8 lanes, bypass read mode: DO follows DI on writes, holds when CE is low.
  initial begin : ram_model
    for (int l = 0; l < 4; l++)
      for (int a = 0; a < WORDS; a++)
        ram_mem[l][a] <= 8'h00;
    ram_dout <= '0;
    forever begin
      @(posedge clk);
      for (int l = 0; l < 4; l++) begin
        if (ram_ce[l]) begin
          if (ram_wre[l]) begin
            ram_mem[l][ram_ad] <= ram_din[8*l +: 8];
            ram_dout[8*l +: 8] <= ram_din[8*l +: 8];
          end else begin
            ram_dout[8*l +: 8] <= ram_mem[l][ram_ad];
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_word(input int wa);
    return {ref_mem[4*wa+3], ref_mem[4*wa+2], ref_mem[4*wa+1], ref_mem[4*wa]};
  endfunction

  function automatic void ref_load(input bit complete);
    int k = 0;
    ref_lock = 1'b0;
    foreach (img[i]) begin
      if (k < NB) begin
        ref_mem[k] = img[i];
        k++;
      end
    end
    if (complete) ref_lock = WPROT;
  endfunction

  task automatic fill_img(input int len);
    img.delete();
    repeat (len) img.push_back(8'($urandom_range(0, 255)));
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (resetn && mem_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_ready", mem_ready, 1'b0);
      end else begin
        e = sb_q.pop_front();
        if (e.is_rd) chk("rdata", mem_rdata, e.data);
`ifdef BOOTRAM_CTRL_WPROT_EN
        chk("wprot_err", wprot_err, e.prot & ~e.is_rd);
`endif
      end
    end
`ifdef BOOTRAM_CTRL_WPROT_EN
    else if (resetn) begin
      chk("wprot_err_idle", wprot_err, 1'b0);
    end
`endif
  end

  task automatic clear_inputs();
    mem_valid = 0; mem_sel = 0; mem_addr = '0; mem_wstrb = '0; mem_wdata = '0;
    ld_valid = 0; ld_data = '0; ld_last = 0;
  endtask

  task automatic chk_reset();
    chk("reset_flags", {mem_ready, ld_ready, ld_done, ld_ovf, ram_ce, ram_wre}, '0);
    chk("reset_rdata", mem_rdata, '0);
    chk("reset_ram_ad_din", {ram_ad, ram_din}, '0);
`ifdef BOOTRAM_CTRL_WPROT_EN
    chk("reset_wprot_err", wprot_err, 1'b0);
`endif
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 0;
    clear_inputs();
    #1 chk_reset();
    exp_ovf = 0;
    ref_lock = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1;
  endtask

  task automatic drive_load(input bit has_last);
    int k, n;
    logic [7:0] b;
    logic [3:0] exp_ce;
    k = 0;
    @(posedge clk); #1;
    for (int i = 0; i < img.size(); i++) begin
      b = img[i];
      if (i > 0 && $urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
      end
      ld_valid = 1; ld_data = b; ld_last = has_last && (i == img.size() - 1);
      n = 0;
      do begin
        @(negedge clk); n++;
      end while (!ld_ready && n < 50);
      chk("ld_ready_wait", ld_ready, 1'b1);
      if (!ld_ready) begin
        ld_valid = 0; ld_last = 0;
        return;
      end
      exp_ce = (k < NB) ? 4'(1 << (k % 4)) : 4'h0;
      chk("ld_lane_en", {ram_ce, ram_wre}, {exp_ce, exp_ce});
      if (k < NB) chk("ld_addr_data", {ram_ad, ram_din}, {11'(k / 4), {4{b}}});
      @(posedge clk); #1;
      if (k < NB) k++;
      else exp_ovf = 1;
      ld_valid = 0; ld_last = 0;
      chk("ld_ovf", ld_ovf, exp_ovf);
    end
    if (has_last) begin
      chk("ld_done_pulse", ld_done, 1'b1);
      done_cyc = cyc;
      @(posedge clk); #1;
      chk("ld_done_clear", ld_done, 1'b0);
    end
  endtask

  task automatic cpu_op(input logic [12:0] addr, input logic [3:0] strb,
                        input logic [31:0] wd, input bit contended);
    exp_t e;
    int wa, n;
    logic [3:0] exp_ce;
    wa = int'(addr[12:2]);
    if (strb == 0) begin
      e.is_rd = 1; e.prot = 0; e.data = ref_word(wa);
      exp_ce = 4'hF;
    end else begin
      e.is_rd = 0; e.prot = ref_lock; e.data = '0;
      if (!ref_lock)
        for (int l = 0; l < 4; l++)
          if (strb[l]) ref_mem[4*wa+l] = wd[8*l +: 8];
      exp_ce = ref_lock ? 4'h0 : strb;
    end
    sb_q.push_back(e);
    @(posedge clk); #1;
    mem_valid = 1; mem_sel = 1; mem_addr = addr; mem_wstrb = strb; mem_wdata = wd;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1) begin
        if (contended) begin
          chk("stall_no_ram", {ram_ce, ram_wre}, '0);
        end else begin
          chk("cpu_lane_en", {ram_ce, ram_wre}, {exp_ce, (strb == 0) ? 4'h0 : exp_ce});
          chk("cpu_addr", ram_ad, addr[12:2]);
          if (strb != 0) chk("cpu_wdata", ram_din, wd);
        end
      end
    end while (!mem_ready && n < 200);
    chk("mem_ready_wait", mem_ready, 1'b1);
    if (!contended && mem_ready)
      chk((strb == 0) ? "rd_latency" : "wr_latency", n, (strb == 0) ? 3 : 2);
    ready_cyc = cyc;
    @(posedge clk); #1;
    mem_valid = 0; mem_sel = 0; mem_wstrb = '0;
  endtask

  initial begin : watchdog
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation still running at time limit (expected completion)");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : main
    logic [10:0] wa;
    logic [12:0] addr;
    logic [3:0]  strb;
    int          op, bad;

    for (int i = 0; i < NB; i++) ref_mem[i] = 8'h00;
    ref_lock = 0;
    exp_ovf = 0;
    resetn = 0;
    clear_inputs();
    #1 chk_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) resetn = 1;

    // Single-lane CPU write, then readback of the whole word.
    cpu_op(13'h0010, 4'b0010, 32'hAABBCCDD, 0);
    cpu_op(13'h0010, 4'b0000, 32'h0, 0);

    // Unselected requests must not touch the lanes or acknowledge.
    @(posedge clk); #1;
    mem_valid = 1; mem_sel = 0; mem_addr = 13'h0020; mem_wstrb = 4'hF; mem_wdata = $urandom;
    repeat (4) begin
      @(negedge clk);
      chk("nosel_ignored", {mem_ready, ram_ce, ram_wre}, '0);
    end
    @(posedge clk); #1;
    mem_valid = 0; mem_wstrb = '0;

    img.delete();
    img.push_back(8'h11); img.push_back(8'h22); img.push_back(8'h33); img.push_back(8'h44);
    ref_load(1);
    drive_load(1);
    cpu_op(13'h0000, 4'b0000, 32'h0, 0);

    // Full-word write after a completed load; blocked only when the lock is built in.
    cpu_op(13'h0000, 4'hF, 32'hFFFFFFFF, 0);
    cpu_op(13'h0000, 4'b0000, 32'h0, 0);

    // Loader and CPU read arrive in the same idle cycle.
    fill_img(4);
    ref_load(1);
    fork
      drive_load(1);
      cpu_op(13'h0000, 4'b0000, 32'h0, 1);
    join
    chk("stall_release_cycle", ready_cyc, done_cyc + 3);

    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 4);
      if (op == 0) begin
        fill_img($urandom_range(1, 10));
        ref_load(1);
        drive_load(1);
      end else begin
        wa = ($urandom_range(0, 1) == 1) ? 11'($urandom_range(0, WORDS - 1)) : 11'($urandom_range(0, 7));
        addr = {wa, 2'($urandom_range(0, 3))};
        strb = (op >= 3) ? 4'($urandom_range(1, 15)) : 4'h0;
        cpu_op(addr, strb, $urandom, 0);
      end
    end

    // Capacity overflow: 8193 bytes, then the last marker on a dropped byte.
    fill_img(NB + 2);
    ref_load(1);
    drive_load(1);
    cpu_op({11'(WORDS - 1), 2'b00}, 4'b0000, 32'h0, 0);
    cpu_op(13'h0000, 4'b0000, 32'h0, 0);

    // Reset in the middle of a load, then a one-byte image.
    fill_img(5);
    ref_load(0);
    drive_load(0);
    do_reset();
    img.delete();
    img.push_back(8'h5A);
    ref_load(1);
    drive_load(1);
    cpu_op(13'h0000, 4'b0000, 32'h0, 0);

    repeat (5) @(posedge clk);
    bad = 0;
    for (int w = 0; w < WORDS; w++)
      for (int l = 0; l < 4; l++)
        if (ram_mem[l][w] !== ref_mem[4*w+l]) bad++;
    chk("ram_image_bad_bytes", bad, 0);
    chk("scoreboard_left", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
